data_fetch_ctrl: RTL and testbench
==================================

DATA_FETCH_CTRL -- requirements
Module: data_fetch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64: maximum cycles spent in LOAD or STORE before the block aborts.
REQ-002 SHALL have parameter BRAM_LAT, default 1: BRAM read latency in cycles, drained after each fetch.
REQ-003 SHALL have port CLK, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-004 SHALL have port RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port INSTR_VALID, input, 1 bit: a command is offered.
REQ-006 SHALL have port INSTR_READY, output, 1 bit: the block accepts a command.
REQ-007 SHALL have port OPCODE, input, 3 bits: 0 LOAD_BCAST, 1 LOAD_ONE, 2 LOAD_A, 3 LOAD_B, 4 STORE; values 5-7 are illegal.
REQ-008 SHALL have port BASE_ADDR, input, 17 bits: BRAM base word address.
REQ-009 SHALL have port DIMEN_IN, input, 2 bits: matrix dimension code (2x2, 4x4, 8x8, 16x16+).
REQ-010 SHALL have port PE_TARGET, input, 2 bits: PE index for LOAD_ONE, or half select for LOAD_A/LOAD_B.
REQ-011 SHALL have ports DIMEN (2 bits), ADDRESS (17 bits), PE_SEL (2 bits), and 1-bit PE_SEL_2x2, PE_SEL_4, ADDR_START, ADDR_RST, WRADDR_START, all outputs driving the fetch datapath.
REQ-012 SHALL have ports FETCH_DONE and STORE_DONE, inputs, 1 bit each: completion flags from the datapath.
REQ-013 SHALL have ports DONE and ERR, outputs, 1 bit each: one-cycle completion and abort pulses.
REQ-014 SHALL have port BUSY, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, CLEAR, LOAD, DRAIN, STORE, FINISH.
REQ-016 INSTR_READY SHALL be high only in IDLE.
- A command is accepted on the cycle INSTR_VALID and INSTR_READY are both high.
- On accept, OPCODE, BASE_ADDR, DIMEN_IN and PE_TARGET SHALL be registered and held stable on the outputs until FINISH.
REQ-017 An accepted illegal OPCODE SHALL skip the operation and go IDLE->FINISH, with ERR=1 and DONE=0 in FINISH.
REQ-018 CLEAR SHALL last exactly 1 cycle with ADDR_RST=1, then go to LOAD for any load opcode or STORE for STORE.
REQ-019 In LOAD:
- ADDR_START SHALL be 1.
- On FETCH_DONE=1, the FSM SHALL go to DRAIN.
REQ-020 In DRAIN:
- ADDR_START SHALL be 0.
- The FSM SHALL stay exactly BRAM_LAT cycles, then go to FINISH.
REQ-021 In STORE:
- WRADDR_START SHALL be 1.
- On STORE_DONE=1, the FSM SHALL go to FINISH.
REQ-022 PE select encoding by opcode:
- LOAD_BCAST: PE_SEL=0.
- LOAD_ONE: PE_SEL=1, PE_SEL_4=PE_TARGET[1], PE_SEL_2x2=PE_TARGET[0].
- LOAD_A: PE_SEL=2, PE_SEL_2x2=~PE_TARGET[0].
- LOAD_B: PE_SEL=3, PE_SEL_2x2=~PE_TARGET[0].
- STORE and IDLE: PE_SEL=0, PE_SEL_2x2=0, PE_SEL_4=0.
REQ-023 A timeout counter SHALL:
- clear on entry to LOAD or STORE and increment each cycle spent there;
- when it reaches TIMEOUT_CYC-1 without the matching done flag, force a go to FINISH with ERR=1, DONE=0.
- The done flag SHALL win if it arrives on that same cycle.
REQ-024 FINISH SHALL last 1 cycle with ADDR_RST=1, drive DONE=1 unless ERR=1, and then go to IDLE.
REQ-025 ADDR_START and WRADDR_START SHALL never be high together.
REQ-026 FETCH_DONE during STORE and STORE_DONE during LOAD SHALL be ignored.
REQ-027 A new command SHALL NOT be accepted in the FINISH cycle; the minimum issue interval is 1 + 1 + N + 1 cycles.

Reset
REQ-028 RSTN=0 SHALL immediately force:
- FSM to IDLE and the timeout counter to 0;
- all registered command fields to 0;
- ADDR_START=0, WRADDR_START=0, DONE=0, ERR=0, BUSY=0;
- ADDR_RST=1 while reset is asserted, and INSTR_READY=0 while reset is asserted.
REQ-029 Reset during any state, including mid-LOAD or mid-STORE, SHALL abort the operation with no DONE or ERR pulse.
- Outputs SHALL follow REQ-028 within the same cycle.
- Operation SHALL resume from IDLE on the first CLK edge after RSTN rises.

Structure
REQ-030 A shared package SHALL hold the opcode enum, the FSM state enum, and the DIMEN codes.
REQ-031 The timeout counter SHALL be a sub-module, op_timer (load, enable, expire).
- The FSM and output decode SHALL stay in data_fetch_ctrl.

Verification
REQ-032 LOAD_BCAST, DIMEN_IN=1, BASE_ADDR=0x100, FETCH_DONE modelled at the 5th LOAD cycle -> ADDRESS=0x100, ADDR_RST one cycle, ADDR_START for 5 cycles, DRAIN 1 cycle, DONE pulse, BUSY for 8 cycles.
REQ-033 LOAD_ONE, PE_TARGET=2 -> PE_SEL=1, PE_SEL_4=1, PE_SEL_2x2=0 throughout LOAD.
REQ-034 STORE, STORE_DONE at the 4th cycle -> WRADDR_START high for 4 cycles, ADDR_START=0 throughout, DONE once.
REQ-035 LOAD with FETCH_DONE never asserted, TIMEOUT_CYC=64 -> ERR pulse after 64 LOAD cycles, no DONE, FSM back in IDLE.
REQ-036 RSTN low for 1 cycle at the 3rd LOAD cycle -> ADDR_START drops asynchronously, no DONE or ERR, next command accepted normally.
REQ-037 OPCODE=6 -> ERR pulse, ADDR_START and WRADDR_START never asserted; back-to-back valid commands accepted only in IDLE.

Source files
------------

// File: rtl/data_fetch_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_fetch_ctrl_pkg                                              |
// | Shared opcode, FSM state, DIMEN and PE-select encodings.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package data_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_LOAD_BCAST = 3'd0,
        OP_LOAD_ONE   = 3'd1,
        OP_LOAD_A     = 3'd2,
        OP_LOAD_B     = 3'd3,
        OP_STORE      = 3'd4
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_STORE  = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    localparam logic [1:0] DIMEN_2X2   = 2'd0;
    localparam logic [1:0] DIMEN_4X4   = 2'd1;
    localparam logic [1:0] DIMEN_8X8   = 2'd2;
    localparam logic [1:0] DIMEN_16X16 = 2'd3;

    localparam logic [1:0] PE_SEL_BCAST = 2'd0;
    localparam logic [1:0] PE_SEL_ONE   = 2'd1;
    localparam logic [1:0] PE_SEL_A     = 2'd2;
    localparam logic [1:0] PE_SEL_B     = 2'd3;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'(OP_STORE));
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_fetch_ctrl_op_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | op_timer                                                         |
// | Per-operation watchdog: cleared by load, counts while enabled.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module op_timer #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_enable,
    output logic o_expire
);

    localparam int            C_CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(LIMIT - 1);

    logic [C_CW-1:0] r_count;

    // Saturates at the last value so a held enable never wraps back to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_enable && !o_expire) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/data_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_fetch_ctrl                                                  |
// | Command FSM sequencing BRAM fetch/store for the PE array.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module data_fetch_ctrl #(
    parameter int TIMEOUT_CYC = 64,
    parameter int BRAM_LAT    = 1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    input  logic [2:0]  OPCODE,
    input  logic [16:0] BASE_ADDR,
    input  logic [1:0]  DIMEN_IN,
    input  logic [1:0]  PE_TARGET,
    output logic [1:0]  DIMEN,
    output logic [16:0] ADDRESS,
    output logic [1:0]  PE_SEL,
    output logic        PE_SEL_2x2,
    output logic        PE_SEL_4,
    output logic        ADDR_START,
    output logic        ADDR_RST,
    output logic        WRADDR_START,
    input  logic        FETCH_DONE,
    input  logic        STORE_DONE,
    output logic        DONE,
    output logic        ERR,
    output logic        BUSY
);

    import data_fetch_ctrl_pkg::*;

    localparam int            C_DW         = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;
    localparam logic [C_DW-1:0] C_DRAIN_LAST = C_DW'(BRAM_LAT - 1);

    state_e          r_state;
    logic [2:0]      r_opcode;
    logic [16:0]     r_addr;
    logic [1:0]      r_dimen;
    logic [1:0]      r_target;
    logic            r_err;
    logic [C_DW-1:0] r_drain;

    logic w_accept;
    logic w_expire;

    assign w_accept = INSTR_VALID && INSTR_READY;

    // Every entry into LOAD/STORE passes through CLEAR, so CLEAR restarts the watchdog
    op_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_op_timer (
        .clk      (CLK),
        .rst_n    (RSTN),
        .i_load   (r_state == ST_CLEAR),
        .i_enable ((r_state == ST_LOAD) || (r_state == ST_STORE)),
        .o_expire (w_expire)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
            r_addr   <= '0;
            r_dimen  <= '0;
            r_target <= '0;
            r_err    <= 1'b0;
            r_drain  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_opcode <= OPCODE;
                        r_addr   <= BASE_ADDR;
                        r_dimen  <= DIMEN_IN;
                        r_target <= PE_TARGET;
                        r_err    <= !is_legal_op(OPCODE);
                        r_state  <= is_legal_op(OPCODE) ? ST_CLEAR : ST_FINISH;
                    end
                end
                ST_CLEAR: begin
                    r_state <= (r_opcode == 3'(OP_STORE)) ? ST_STORE : ST_LOAD;
                end
                ST_LOAD: begin
                    if (FETCH_DONE) begin
                        r_drain <= '0;
                        r_state <= ST_DRAIN;
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_state <= ST_FINISH;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == C_DRAIN_LAST) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                ST_STORE: begin
                    if (STORE_DONE) begin
                        r_state <= ST_FINISH;
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Reset gates READY low and ADDR_RST high without waiting for a clock
    assign INSTR_READY  = RSTN && (r_state == ST_IDLE);
    assign ADDR_RST     = !RSTN || (r_state == ST_CLEAR) || (r_state == ST_FINISH);
    assign ADDR_START   = (r_state == ST_LOAD);
    assign WRADDR_START = (r_state == ST_STORE);
    assign BUSY         = (r_state != ST_IDLE);
    assign DONE         = (r_state == ST_FINISH) && !r_err;
    assign ERR          = (r_state == ST_FINISH) && r_err;
    assign ADDRESS      = r_addr;
    assign DIMEN        = r_dimen;

    always_comb begin
        PE_SEL     = PE_SEL_BCAST;
        PE_SEL_4   = 1'b0;
        PE_SEL_2x2 = 1'b0;
        if (r_state != ST_IDLE) begin
            case (r_opcode)
                3'(OP_LOAD_ONE): begin
                    PE_SEL     = PE_SEL_ONE;
                    PE_SEL_4   = r_target[1];
                    PE_SEL_2x2 = r_target[0];
                end
                3'(OP_LOAD_A): begin
                    PE_SEL     = PE_SEL_A;
                    PE_SEL_2x2 = ~r_target[0];
                end
                3'(OP_LOAD_B): begin
                    PE_SEL     = PE_SEL_B;
                    PE_SEL_2x2 = ~r_target[0];
                end
                default: begin
                    PE_SEL     = PE_SEL_BCAST;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_data_fetch_ctrl                                               |
// | Vector table plus scoreboard bench for data_fetch_ctrl.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_data_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        INSTR_VALID = 1'b0;
    logic        INSTR_READY;
    logic [2:0]  OPCODE = '0;
    logic [16:0] BASE_ADDR = '0;
    logic [1:0]  DIMEN_IN = '0;
    logic [1:0]  PE_TARGET = '0;
    logic [1:0]  DIMEN;
    logic [16:0] ADDRESS;
    logic [1:0]  PE_SEL;
    logic        PE_SEL_2x2;
    logic        PE_SEL_4;
    logic        ADDR_START;
    logic        ADDR_RST;
    logic        WRADDR_START;
    logic        FETCH_DONE = 1'b0;
    logic        STORE_DONE = 1'b0;
    logic        DONE;
    logic        ERR;
    logic        BUSY;

    data_fetch_ctrl #(
        .TIMEOUT_CYC (64),
        .BRAM_LAT    (1)
    ) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .INSTR_VALID  (INSTR_VALID),
        .INSTR_READY  (INSTR_READY),
        .OPCODE       (OPCODE),
        .BASE_ADDR    (BASE_ADDR),
        .DIMEN_IN     (DIMEN_IN),
        .PE_TARGET    (PE_TARGET),
        .DIMEN        (DIMEN),
        .ADDRESS      (ADDRESS),
        .PE_SEL       (PE_SEL),
        .PE_SEL_2x2   (PE_SEL_2x2),
        .PE_SEL_4     (PE_SEL_4),
        .ADDR_START   (ADDR_START),
        .ADDR_RST     (ADDR_RST),
        .WRADDR_START (WRADDR_START),
        .FETCH_DONE   (FETCH_DONE),
        .STORE_DONE   (STORE_DONE),
        .DONE         (DONE),
        .ERR          (ERR),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  op;
        logic [16:0] base;
        logic [1:0]  dim;
        logic [1:0]  tgt;
        int          done_at;   // active cycle carrying the done flag, 0 = never
        bit          noise;     // hold the other op's done flag high throughout
        int          exp_astart;
        int          exp_wr;
        int          exp_busy;
        bit          exp_done;
        bit          exp_err;
        logic [3:0]  exp_pe;    // {PE_SEL, PE_SEL_4, PE_SEL_2x2}
    } vec_t;

    typedef struct {
        int astart;
        int wr;
        int busy;
        int arst;
        bit done;
        bit err;
    } exp_t;

    vec_t vecs[12];
    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   astart = 0;
        int   wr = 0;
        int   busy = 0;
        int   arst = 0;
        int   pulses = 0;
        int   overlap = 0;
        bit   is_store = (v.op == 3'd4);
        bit   ended = 1'b0;
        bit   got_ready = 1'b0;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (INSTR_READY) begin
                got_ready = 1'b1;
                break;
            end
        end
        check($sformatf("v%0d_ready_wait", idx), got_ready, 1);
        INSTR_VALID = 1'b1;
        OPCODE      = v.op;
        BASE_ADDR   = v.base;
        DIMEN_IN    = v.dim;
        PE_TARGET   = v.tgt;
        e.astart = v.exp_astart;
        e.wr     = v.exp_wr;
        e.busy   = v.exp_busy;
        e.arst   = (v.op > 3'd4) ? 1 : 2;
        e.done   = v.exp_done;
        e.err    = v.exp_err;
        sb_q.push_back(e);
        for (int i = 0; i < 150; i++) begin
            @(negedge CLK);
            INSTR_VALID = 1'b0;
            if (!BUSY) begin
                ended = 1'b1;
                break;
            end
            busy++;
            if (ADDR_RST) arst++;
            if (ADDR_START && WRADDR_START) overlap++;
            if (ADDR_START) astart++;
            if (WRADDR_START) wr++;
            if (ADDR_START || WRADDR_START) begin
                check($sformatf("v%0d_pe", idx), {PE_SEL, PE_SEL_4, PE_SEL_2x2}, v.exp_pe);
                check($sformatf("v%0d_address", idx), ADDRESS, v.base);
                check($sformatf("v%0d_dimen", idx), DIMEN, v.dim);
            end
            FETCH_DONE = is_store ? v.noise : 1'b0;
            STORE_DONE = is_store ? 1'b0 : v.noise;
            if (ADDR_START && v.done_at != 0 && astart == v.done_at) FETCH_DONE = 1'b1;
            if (WRADDR_START && v.done_at != 0 && wr == v.done_at) STORE_DONE = 1'b1;
            if (DONE || ERR) begin
                pulses++;
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d_sb_unexpected", idx), 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("v%0d_done", idx), DONE, e.done);
                    check($sformatf("v%0d_err", idx), ERR, e.err);
                    check($sformatf("v%0d_busy_cycles", idx), busy, e.busy);
                    check($sformatf("v%0d_addr_start_cycles", idx), astart, e.astart);
                    check($sformatf("v%0d_wraddr_cycles", idx), wr, e.wr);
                    check($sformatf("v%0d_addr_rst_cycles", idx), arst, e.arst);
                    check($sformatf("v%0d_start_overlap", idx), overlap, 0);
                end
            end
        end
        FETCH_DONE = 1'b0;
        STORE_DONE = 1'b0;
        check($sformatf("v%0d_op_ended", idx), ended, 1);
        check($sformatf("v%0d_pulses", idx), pulses, 1);
        check($sformatf("v%0d_idle_ready", idx), INSTR_READY, 1);
    endtask

    initial begin
        int astart;
        int pulses;
        int accepts;
        int errs;
        int ready_busy;

        //           op    base      dim   tgt  done nz  astart wr busy done err pe
        vecs[0]  = '{3'd0, 17'h00100, 2'd1, 2'd0, 5,  0,  5,     0, 8,   1,   0,  4'b0000};
        vecs[1]  = '{3'd1, 17'h1ABCD, 2'd2, 2'd2, 3,  0,  3,     0, 6,   1,   0,  4'b0110};
        vecs[2]  = '{3'd1, 17'h00042, 2'd0, 2'd1, 1,  0,  1,     0, 4,   1,   0,  4'b0101};
        vecs[3]  = '{3'd2, 17'h0F0F0, 2'd3, 2'd0, 2,  0,  2,     0, 5,   1,   0,  4'b1001};
        vecs[4]  = '{3'd3, 17'h12345, 2'd1, 2'd1, 2,  0,  2,     0, 5,   1,   0,  4'b1100};
        vecs[5]  = '{3'd4, 17'h00800, 2'd2, 2'd3, 4,  1,  0,     4, 6,   1,   0,  4'b0000};
        vecs[6]  = '{3'd0, 17'h1FFFF, 2'd0, 2'd0, 2,  1,  2,     0, 5,   1,   0,  4'b0000};
        vecs[7]  = '{3'd2, 17'h00200, 2'd1, 2'd1, 0,  0,  64,    0, 66,  0,   1,  4'b1000};
        vecs[8]  = '{3'd3, 17'h00300, 2'd2, 2'd0, 64, 0,  64,    0, 67,  1,   0,  4'b1101};
        vecs[9]  = '{3'd4, 17'h00400, 2'd3, 2'd0, 0,  1,  0,     64, 66, 0,   1,  4'b0000};
        vecs[10] = '{3'd6, 17'h00500, 2'd1, 2'd2, 0,  0,  0,     0, 1,   0,   1,  4'b0000};
        vecs[11] = '{3'd5, 17'h00600, 2'd0, 2'd1, 0,  0,  0,     0, 1,   0,   1,  4'b0000};

        // Reset state
        #3;
        check("rst_addr_rst", ADDR_RST, 1);
        check("rst_ready", INSTR_READY, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done_err", {DONE, ERR}, 0);
        check("rst_starts", {ADDR_START, WRADDR_START}, 0);
        check("rst_address", ADDRESS, 0);
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset asserted mid-LOAD aborts with no pulse
        @(negedge CLK);
        INSTR_VALID = 1'b1;
        OPCODE      = 3'd0;
        BASE_ADDR   = 17'h00777;
        DIMEN_IN    = 2'd1;
        PE_TARGET   = 2'd0;
        astart = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            INSTR_VALID = 1'b0;
            if (DONE || ERR) pulses++;
            if (ADDR_START) astart++;
            if (astart == 3) break;
        end
        check("midrst_reached_load3", astart, 3);
        #2 RSTN = 1'b0;
        #1;
        check("midrst_addr_start", ADDR_START, 0);
        check("midrst_addr_rst", ADDR_RST, 1);
        check("midrst_ready", INSTR_READY, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_address", ADDRESS, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (DONE || ERR) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);
        run_vec(12, vecs[0]);

        // Back-to-back illegal commands: accepted only in IDLE
        @(negedge CLK);
        INSTR_VALID = 1'b1;
        OPCODE      = 3'd6;
        accepts = 0;
        errs = 0;
        ready_busy = 0;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge CLK);
            if (INSTR_READY) accepts++;
            if (ERR) errs++;
            if (INSTR_READY && BUSY) ready_busy++;
            if (ADDR_START || WRADDR_START) ready_busy++;
        end
        INSTR_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("b2b_accepts", accepts, 5);
        check("b2b_errs", errs, 5);
        check("b2b_ready_or_start_while_busy", ready_busy, 0);
        check("b2b_idle_end", BUSY, 0);

        check("sb_leftover", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
